// File: rtl/stair_pkg.sv
// Shared types and constants for the stair scroll engine.
package stair_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    DRAW  = 3'd2,
    WAIT  = 3'd3,
    ERASE = 3'd4,
    MOVE  = 3'd5
  } state_t;

  localparam int BLACK = 0;

  // Row a stair jumps to after scrolling off the top of the screen.
  function automatic int wrap_target(input int screen_h, input int stair_h);
    return screen_h - stair_h;
  endfunction

endpackage

// File: rtl/pixel_scan_counter.sv
// Nested col/row/stair counter used for both the draw and the erase pass.
module pixel_scan_counter #(
  parameter int COLS  = 40,
  parameter int ROWS  = 5,
  parameter int COUNT = 2,
  localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1,
  localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1,
  localparam int KW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          clear,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [KW-1:0] k,
  output logic          last
);

  logic col_end, row_end, k_end;

  assign col_end = (col == CW'(COLS - 1));
  assign row_end = (row == RW'(ROWS - 1));
  assign k_end   = (k == KW'(COUNT - 1));
  assign last    = col_end && row_end && k_end;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      col <= '0;
      row <= '0;
      k   <= '0;
    end else if (enable) begin
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row <= '0;
          k   <= k_end ? '0 : k + KW'(1);
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stair_scroll_engine.sv
// Draws, erases and scrolls N_STAIRS rectangles on the VGA pixel stream.
// Optional per-stair colour palette enabled by defining STAIR_PALETTE_EN.
module stair_scroll_engine
  import stair_pkg::*;
#(
  parameter int N_STAIRS        = 2,
  parameter int STAIR_W         = 40,
  parameter int STAIR_H         = 5,
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int COLOUR_W        = 3,
  parameter int SCREEN_W        = 160,
  parameter int SCREEN_H        = 120,
  parameter int FRAME_DIV       = 833334,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    go,
  input  logic [N_STAIRS*X_W-1:0] init_x,
  input  logic [N_STAIRS*Y_W-1:0] init_y,
  input  logic [COLOUR_W-1:0]     fg_colour,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [COLOUR_W-1:0]     colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    step_done,
  output state_t                  dbg_state
);

  localparam int CW     = (STAIR_W > 1) ? $clog2(STAIR_W) : 1;
  localparam int RW     = (STAIR_H > 1) ? $clog2(STAIR_H) : 1;
  localparam int KW     = (N_STAIRS > 1) ? $clog2(N_STAIRS) : 1;
  localparam int FDW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int FPW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int WRAP_Y = wrap_target(SCREEN_H, STAIR_H);

  state_t             state;
  logic [X_W-1:0]     pos_x [N_STAIRS];
  logic [Y_W-1:0]     pos_y [N_STAIRS];
  logic [FDW-1:0]     div_cnt;
  logic [FPW-1:0]     tick_cnt;
  logic               scanning;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [KW-1:0]      k;
  logic               last;
  logic [X_W:0]       x_sum;
  logic [Y_W-1:0]     y_sum;
  logic [COLOUR_W-1:0] draw_colour;

  assign dbg_state = state;
  assign scanning  = (state == DRAW) || (state == ERASE);

  pixel_scan_counter #(
    .COLS  (STAIR_W),
    .ROWS  (STAIR_H),
    .COUNT (N_STAIRS)
  ) u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (scanning),
    .clear   (!scanning),
    .col     (col),
    .row     (row),
    .k       (k),
    .last    (last)
  );

  // x_sum keeps the carry so columns past the right edge can be clipped.
  always_comb begin
    x_sum = {1'b0, pos_x[k]} + (X_W+1)'(col);
    y_sum = pos_y[k] + Y_W'(row);
  end

`ifdef STAIR_PALETTE_EN
  logic [COLOUR_W-1:0] pal_colour;
  always_comb begin
    pal_colour  = fg_colour + COLOUR_W'(k);
    draw_colour = (pal_colour == '0) ? fg_colour : pal_colour;
  end
`else
  assign draw_colour = fg_colour;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      step_done <= 1'b0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      for (int i = 0; i < N_STAIRS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      step_done <= 1'b0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      case (state)
        IDLE: if (go) state <= ARM;
        ARM: begin
          if (!go) begin
            state <= DRAW;
            busy  <= 1'b1;
            for (int i = 0; i < N_STAIRS; i++) begin
              pos_x[i] <= init_x[i*X_W +: X_W];
              pos_y[i] <= (init_y[i*Y_W +: Y_W] > Y_W'(WRAP_Y)) ?
                          Y_W'(WRAP_Y) : init_y[i*Y_W +: Y_W];
            end
          end
        end
        DRAW: if (last) state <= WAIT;
        WAIT: begin
          // Frame divider and frame-tick counter both restart on WAIT entry.
          if (div_cnt == FDW'(FRAME_DIV - 1)) begin
            if (tick_cnt == FPW'(FRAMES_PER_STEP - 1)) state <= ERASE;
            else tick_cnt <= tick_cnt + FPW'(1);
          end else begin
            div_cnt  <= div_cnt + FDW'(1);
            tick_cnt <= tick_cnt;
          end
        end
        ERASE: begin
          if (last) begin
            state     <= MOVE;
            step_done <= 1'b1;
          end
        end
        MOVE: begin
          state <= DRAW;
          for (int i = 0; i < N_STAIRS; i++) begin
            pos_y[i] <= (pos_y[i] == '0) ? Y_W'(WRAP_Y) : pos_y[i] - Y_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (scanning) begin
      x      <= x_sum[X_W-1:0];
      y      <= y_sum;
      colour <= (state == ERASE) ? COLOUR_W'(BLACK) : draw_colour;
      plot   <= (x_sum < (X_W+1)'(SCREEN_W));
    end else begin
      plot   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stair_scroll_engine.sv
// Directed bench for stair_scroll_engine with a small stair geometry.
module tb_stair_scroll_engine;
  import stair_pkg::*;

  localparam int PW = 8 + 7 + 3 + 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [15:0] init_x = '0;
  logic [13:0] init_y = '0;
  logic [2:0]  fg_colour = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, step_done;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  stair_scroll_engine #(
    .N_STAIRS(2), .STAIR_W(4), .STAIR_H(2), .X_W(8), .Y_W(7), .COLOUR_W(3),
    .SCREEN_W(160), .SCREEN_H(8), .FRAME_DIV(3), .FRAMES_PER_STEP(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .init_x(init_x), .init_y(init_y),
    .fg_colour(fg_colour), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .step_done(step_done), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    go = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic do_start(input int x0, input int y0, input int x1, input int y1,
                          input logic [2:0] c);
    init_x = {8'(x1), 8'(x0)};
    init_y = {7'(y1), 7'(y0)};
    fg_colour = c;
    go = 1'b1;
    repeat (3) tick();
    go = 1'b0;
    tick();
  endtask

  function automatic logic [2:0] pal(input logic [2:0] c, input int kk);
    logic [2:0] p;
`ifdef STAIR_PALETTE_EN
    p = c + 3'(kk);
    if (p == 3'd0) p = c;
`else
    p = c;
`endif
    return p;
  endfunction

  // Expected pixel stream of one pass: stair, then row, then column.
  task automatic build_pass(input int x0, input int y0, input int x1, input int y1,
                            input logic [2:0] c, input logic erase);
    int xs, ys;
    logic [7:0] xv;
    logic [6:0] yv;
    logic [2:0] cv;
    for (int kk = 0; kk < 2; kk++)
      for (int r = 0; r < 2; r++)
        for (int cc = 0; cc < 4; cc++) begin
          xs = ((kk == 0) ? x0 : x1) + cc;
          ys = ((kk == 0) ? y0 : y1) + r;
          xv = xs[7:0];
          yv = ys[6:0];
          cv = erase ? 3'd0 : pal(c, kk);
          exp_q.push_back({xv, yv, cv, (xs < 160)});
        end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    go = 1'b0;
    tick();
    tick();
    n_vec++; if (x !== 8'd0) begin n_err++; $display("FAIL reset_x got %0d want 0", x); end
    n_vec++; if (y !== 7'd0) begin n_err++; $display("FAIL reset_y got %0d want 0", y); end
    n_vec++; if (colour !== 3'd0) begin n_err++; $display("FAIL reset_colour got %0d want 0", colour); end
    n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL reset_plot got %b want 0", plot); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (step_done !== 1'b0) begin n_err++; $display("FAIL reset_step_done got %b want 0", step_done); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    reset_n = 1'b1;
    repeat (3) tick();
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL idle_hold got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_start_draw;
    logic [PW-1:0] obs, want;
    init_x = {8'd50, 8'd10};
    init_y = {7'd5, 7'd3};
    fg_colour = 3'd4;
    go = 1'b1;
    tick();
    n_vec++; if (dbg_state !== ARM) begin n_err++; $display("FAIL arm_entry got %0d want ARM", dbg_state); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arm_busy got %b want 0", busy); end
    tick();
    tick();
    n_vec++; if (dbg_state !== ARM) begin n_err++; $display("FAIL arm_hold got %0d want ARM", dbg_state); end
    go = 1'b0;
    tick();
    n_vec++; if (dbg_state !== DRAW) begin n_err++; $display("FAIL draw_entry got %0d want DRAW", dbg_state); end
    n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL draw_first_plot got %b want 0", plot); end
    build_pass(10, 3, 50, 5, 3'd4, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {x, y, colour, plot};
      want = exp_q.pop_front();
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL draw_px%0d got x=%0d y=%0d c=%0d p=%b want x=%0d y=%0d c=%0d p=%b",
                 i, x, y, colour, plot, want[18:11], want[10:4], want[3:1], want[0]);
      end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL draw_busy%0d got %b want 1", i, busy); end
    end
    n_vec++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL wait_entry got %0d want WAIT", dbg_state); end
  endtask

  task automatic test_wait_erase;
    logic [PW-1:0] obs, want;
    go = 1'b1;
    repeat (5) begin
      tick();
      n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL wait_plot got %b want 0", plot); end
      n_vec++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL wait_state got %0d want WAIT", dbg_state); end
    end
    go = 1'b0;
    tick();
    n_vec++; if (dbg_state !== ERASE) begin n_err++; $display("FAIL erase_entry got %0d want ERASE", dbg_state); end
    n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL erase_first_plot got %b want 0", plot); end
    build_pass(10, 3, 50, 5, 3'd4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {x, y, colour, plot};
      want = exp_q.pop_front();
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL erase_px%0d got x=%0d y=%0d c=%0d p=%b want x=%0d y=%0d c=%0d p=%b",
                 i, x, y, colour, plot, want[18:11], want[10:4], want[3:1], want[0]);
      end
      n_vec++;
      if (step_done !== (i == 15)) begin
        n_err++; $display("FAIL erase_step_done%0d got %b want %b", i, step_done, (i == 15));
      end
    end
    n_vec++; if (dbg_state !== MOVE) begin n_err++; $display("FAIL move_state got %0d want MOVE", dbg_state); end
    tick();
    n_vec++; if (step_done !== 1'b0) begin n_err++; $display("FAIL step_pulse_width got %b want 0", step_done); end
    n_vec++; if (dbg_state !== DRAW) begin n_err++; $display("FAIL redraw_state got %0d want DRAW", dbg_state); end
    n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL move_after_plot got %b want 0", plot); end
  endtask

  task automatic test_scroll;
    logic [PW-1:0] obs, want;
    build_pass(10, 2, 50, 4, 3'd4, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {x, y, colour, plot};
      want = exp_q.pop_front();
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL scroll_px%0d got x=%0d y=%0d c=%0d p=%b want x=%0d y=%0d c=%0d p=%b",
                 i, x, y, colour, plot, want[18:11], want[10:4], want[3:1], want[0]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [PW-1:0] obs, want;
    bit seen;
    int pulses;
    apply_reset();
    do_start(20, 0, 60, 6, 3'd2);
    seen = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (step_done) begin seen = 1'b1; pulses++; end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL wrap_step_done got 0 want 1 within 100 cycles"); end
    tick();
    if (step_done) pulses++;
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL wrap_pulses got %0d want 1", pulses); end
    build_pass(20, 6, 60, 5, 3'd2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {x, y, colour, plot};
      want = exp_q.pop_front();
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL wrap_px%0d got x=%0d y=%0d c=%0d p=%b want x=%0d y=%0d c=%0d p=%b",
                 i, x, y, colour, plot, want[18:11], want[10:4], want[3:1], want[0]);
      end
    end
  endtask

  task automatic test_clip;
    logic [PW-1:0] obs, want;
    apply_reset();
    do_start(158, 1, 50, 4, 3'd4);
    build_pass(158, 1, 50, 4, 3'd4, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {x, y, colour, plot};
      want = exp_q.pop_front();
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL clip_px%0d got x=%0d y=%0d c=%0d p=%b want x=%0d y=%0d c=%0d p=%b",
                 i, x, y, colour, plot, want[18:11], want[10:4], want[3:1], want[0]);
      end
    end
    n_vec++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL clip_pass_len got %0d want WAIT", dbg_state); end
  endtask

  task automatic test_reset_mid_draw;
    logic [PW-1:0] obs, want;
    apply_reset();
    do_start(30, 2, 70, 3, 3'd5);
    repeat (5) tick();
    n_vec++;
    if ({plot, x, y} !== {1'b1, 8'd30, 7'd3}) begin
      n_err++; $display("FAIL mid_px5 got p=%b x=%0d y=%0d want p=1 x=30 y=3", plot, x, y);
    end
    reset_n = 1'b0;
    tick();
    n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL abort_plot got %b want 0", plot); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL abort_state got %0d want IDLE", dbg_state); end
    reset_n = 1'b1;
    do_start(40, 7, 90, 0, 3'd6);
    build_pass(40, 6, 90, 0, 3'd6, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {x, y, colour, plot};
      want = exp_q.pop_front();
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL relatch_px%0d got x=%0d y=%0d c=%0d p=%b want x=%0d y=%0d c=%0d p=%b",
                 i, x, y, colour, plot, want[18:11], want[10:4], want[3:1], want[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_draw();
    test_wait_erase();
    test_scroll();
    test_wrap();
    test_clip();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
